spix_regbank_burst: RTL



---
 rtl/spix_pkg.sv | 31 +++
 rtl/spix_dout_shifter.sv | 37 +++
 rtl/spix_regbank_burst.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spix_pkg.sv
// Shared definitions for the burst SPI register bank: opcodes, FSM encoding
// and a ceiling-log2 helper used to size counters.
package spix_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    // Number of bits needed to hold values 0..n-1 (never less than 1).
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spix_dout_shifter.sv
// MISO output shifter: parallel load or shift-left, with the outgoing MSB
// held in its own flop so the pad sees a registered value on the same edge
// the word is loaded.
module spix_dout_shifter #(
    parameter int SWORD = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [SWORD-1:0] i_load_val,
    output logic             o_dout
);

    logic [SWORD-1:0] r_sh;
    logic             r_dout;

    // Load has priority over shift; the output flop tracks the new MSB.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh   <= '0;
            r_dout <= 1'b0;
        end else if (i_load) begin
            r_sh   <= i_load_val;
            r_dout <= i_load_val[SWORD-1];
        end else if (i_shift) begin
            r_sh   <= {r_sh[SWORD-2:0], 1'b0};
            r_dout <= r_sh[SWORD-2];
        end else begin
            r_sh   <= r_sh;
            r_dout <= r_dout;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/spix_regbank_burst.sv
// SPI-slave register bank with burst auto-increment, per-word write/read
// strobes and a sticky frame-error flag. Single clock domain (SPI CLK).
module spix_regbank_burst
    import spix_pkg::*;
#(
    parameter int REGISTERS = 8,
    parameter int INPUTS    = 6,
    parameter int SWORD     = 8,
    parameter int AW        = 3,
    parameter int BURST     = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CEB,
    input  logic                       DATA,
    output logic                       DOUT_DAT,
    output logic                       DOUT_EN,
    output logic [REGISTERS*SWORD-1:0] R,
    output logic [REGISTERS-1:0]       WSTB,
    input  logic [INPUTS*SWORD-1:0]    RD,
    output logic [INPUTS-1:0]          RSTB,
    output logic                       ERR
);

    localparam int MAXW = (AW > SWORD) ? AW : SWORD;
    localparam int CW   = clogb2(MAXW);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_opc;
    logic [AW-1:0]    r_addr;
    logic [SWORD-1:0] r_wsh;
    logic [SWORD-1:0] r_regs [REGISTERS];
    logic [REGISTERS-1:0] r_wstb;
    logic [INPUTS-1:0]    r_rstb;
    logic                 r_err;

    logic [SWORD-1:0] w_rd_words [INPUTS];
    logic [1:0]       w_opcode;
    logic [AW:0]      w_addr_sh;
    logic [AW-1:0]    w_addr_full;
    logic [AW-1:0]    w_next_addr;
    logic [SWORD-1:0] w_word;
    logic             w_last_addr;
    logic             w_last_bit;
    logic             w_ld;
    logic             w_sh;
    logic             w_rd_req;
    logic [AW-1:0]    w_rd_addr;
    logic             w_rd_ok;
    logic [SWORD-1:0] w_ld_val;
    logic             w_wr;
    logic             w_wr_ok;
    logic             w_dout;

    genvar gi;
    generate
        for (gi = 0; gi < INPUTS; gi++) begin : g_rd
            assign w_rd_words[gi] = RD[(gi+1)*SWORD-1 -: SWORD];
        end
        for (gi = 0; gi < REGISTERS; gi++) begin : g_r
            assign R[(gi+1)*SWORD-1 -: SWORD] = r_regs[gi];
        end
    endgenerate

    // The address including the bit sampled on the current edge.
    assign w_opcode    = {r_opc, DATA};
    assign w_addr_sh   = {r_addr, DATA};
    assign w_addr_full = w_addr_sh[AW-1:0];
    assign w_next_addr = (BURST != 0) ? (r_addr + AW'(1)) : r_addr;
    assign w_word      = {r_wsh[SWORD-2:0], DATA};
    assign w_last_addr = (r_cnt == CW'(AW - 1));
    assign w_last_bit  = (r_cnt == CW'(SWORD - 1));
    assign w_rd_ok     = w_rd_req && (int'(w_rd_addr) < INPUTS);
    assign w_ld_val    = w_rd_ok ? w_rd_words[w_rd_addr] : '0;
    assign w_wr_ok     = w_wr && (int'(r_addr) < REGISTERS);

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: CEB high always returns to IDLE.
    always_comb begin
        w_next = r_state;
        if (CEB) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_OPC;
                ST_OPC: begin
                    if (w_opcode == OP_READ || w_opcode == OP_WRITE) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next = ST_DRAIN;
                    end
                end
                ST_ADDR: begin
                    if (w_last_addr) begin
                        w_next = r_opc ? ST_WDATA : ST_RDATA;
                    end else begin
                        w_next = ST_ADDR;
                    end
                end
                ST_WDATA: w_next = ST_WDATA;
                ST_RDATA: w_next = ST_RDATA;
                ST_DRAIN: w_next = ST_DRAIN;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: shifter load/shift, readout address, write completion.
    always_comb begin
        w_ld      = 1'b0;
        w_sh      = 1'b0;
        w_rd_req  = 1'b0;
        w_rd_addr = '0;
        w_wr      = 1'b0;
        if (CEB) begin
            w_ld = 1'b1;            // loads zero: clears the shifter
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_last_addr && !r_opc) begin
                        w_ld      = 1'b1;
                        w_rd_req  = 1'b1;
                        w_rd_addr = w_addr_full;
                    end else begin
                        w_ld = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_last_bit) begin
                        w_ld      = 1'b1;
                        w_rd_req  = 1'b1;
                        w_rd_addr = w_next_addr;
                    end else begin
                        w_sh = 1'b1;
                    end
                end
                ST_WDATA: w_wr = w_last_bit;
                default:  w_ld = 1'b0;
            endcase
        end
    end

    // Datapath: bit counter, opcode/address/write shifters, registers, strobes, error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_opc  <= 1'b0;
            r_addr <= '0;
            r_wsh  <= '0;
            r_wstb <= '0;
            r_rstb <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wstb <= '0;
            r_rstb <= '0;
            if (CEB) begin
                r_cnt  <= '0;
                r_opc  <= 1'b0;
                r_addr <= '0;
                r_wsh  <= '0;
                // Frame ended inside a write word: the partial word is dropped.
                if (r_state == ST_WDATA && r_cnt != '0) begin
                    r_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_opc <= DATA;
                        r_cnt <= '0;
                    end
                    ST_OPC: begin
                        r_cnt <= '0;
                        if (w_opcode == OP_ILL) begin
                            r_err <= 1'b1;
                        end else if (w_opcode == OP_NOP) begin
                            r_err <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        r_addr <= w_addr_full;
                        r_cnt  <= w_last_addr ? '0 : r_cnt + CW'(1);
                    end
                    ST_WDATA: begin
                        if (w_last_bit) begin
                            r_cnt  <= '0;
                            r_wsh  <= '0;
                            r_addr <= w_next_addr;
                            if (w_wr_ok) begin
                                r_regs[r_addr] <= w_word;
                                r_wstb[r_addr] <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                            r_wsh <= w_word;
                        end
                    end
                    ST_RDATA: begin
                        if (w_last_bit) begin
                            r_cnt  <= '0;
                            r_addr <= w_next_addr;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: r_cnt <= r_cnt;
                endcase
                if (w_rd_ok) begin
                    r_rstb[w_rd_addr] <= 1'b1;
                end
            end
        end
    end

    spix_dout_shifter #(.SWORD(SWORD)) u_dout (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_ld),
        .i_shift    (w_sh),
        .i_load_val (w_ld_val),
        .o_dout     (w_dout)
    );

    assign DOUT_DAT = w_dout;
    assign DOUT_EN  = (r_state == ST_RDATA) && !CEB;
    assign WSTB     = r_wstb;
    assign RSTB     = r_rstb;
    assign ERR      = r_err;

endmodule
